// File: rtl/fifo_rd_stream_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_pkg
// Shared definitions for the async_fifo read-side drain stage:
//   FIFO_RD_SKID_DEPTH - number of entries in the skid buffer
//   occ_t / OCC_*      - skid buffer occupancy encoding (0, 1 or 2 words held)
//   pkt_cnt_w()        - width of the packet beat counter for a given PKT_LEN
// -----------------------------------------------------------------------------
package fifo_rd_stream_pkg;

    localparam int FIFO_RD_SKID_DEPTH = 2;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_FULL  = 2'd2;

    // PKT_LEN=1 still needs a 1-bit counter so the vector is never zero width.
    function automatic int pkt_cnt_w(input int pkt_len);
        return (pkt_len > 1) ? $clog2(pkt_len) : 1;
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// -----------------------------------------------------------------------------
// fifo_rd_skid
// Two-entry in-order buffer that catches FIFO read data one cycle after the
// read was issued. The head entry is presented directly on `head`.
// Ports:
//   rclk, rrst  clock and asynchronous active-high reset
//   wr_en       store wr_data this cycle
//   wr_data     word to store
//   rd_en       drop the head entry this cycle (caller guarantees occ != 0)
//   head        oldest stored word
//   occ         number of stored words (0..2)
// -----------------------------------------------------------------------------
module fifo_rd_skid
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] head,
    output occ_t                  occ
);

    logic [DATA_WIDTH-1:0] tail;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            head <= '0;
            tail <= '0;
            occ  <= OCC_EMPTY;
        end else begin
            case ({wr_en, rd_en})
                2'b10: begin
                    if (occ == OCC_EMPTY) head <= wr_data;
                    else                  tail <= wr_data;
                    occ <= occ + OCC_ONE;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - OCC_ONE;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind whatever
                    // survives the pop.
                    if (occ == OCC_FULL) begin
                        head <= tail;
                        tail <= wr_data;
                    end else begin
                        head <= wr_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Read-side drain stage for async_fifo (rclk domain). Issues FIFO reads,
// absorbs the one-cycle read latency in a 2-entry skid buffer and presents
// the words as a valid/ready stream framed into PKT_LEN-word packets.
// Ports:
//   rclk, rrst   read clock, asynchronous active-high reset
//   fifo_ren     read enable to async_fifo
//   fifo_rdata   FIFO read data, valid one cycle after a successful read
//   fifo_empty   FIFO empty flag
//   m_data, m_valid, m_ready, m_last   output stream
//   rd_count     saturating count of accepted words (FIFO_RD_STATS_EN only)
// Build option: define FIFO_RD_STATS_EN to add the rd_count port and counter.
// -----------------------------------------------------------------------------
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 8
) (
    input  logic                  rclk,
    input  logic                  rrst,
    output logic                  fifo_ren,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    input  logic                  fifo_empty,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
`ifdef FIFO_RD_STATS_EN
   ,output logic [15:0]           rd_count
`endif
);

    localparam int                BEAT_W    = pkt_cnt_w(PKT_LEN);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);

    logic              pop;
    logic              inflight;
    occ_t              occ;
    logic [2:0]        level_next;
    logic [BEAT_W-1:0] beat_cnt;

    assign pop = m_valid && m_ready;

    // Words held after this edge if no new read is issued; a read is only
    // allowed when its data will still find a free skid entry.
    assign level_next = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_ren   = !fifo_empty && !rrst && (level_next < 3'(FIFO_RD_SKID_DEPTH));

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) inflight <= 1'b0;
        else      inflight <= fifo_ren && !fifo_empty;
    end

    fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .rclk    (rclk),
        .rrst    (rrst),
        .wr_en   (inflight),
        .wr_data (fifo_rdata),
        .rd_en   (pop),
        .head    (m_data),
        .occ     (occ)
    );

    assign m_valid = (occ != OCC_EMPTY);
    assign m_last  = m_valid && (beat_cnt == BEAT_LAST);

    // Held while the FIFO runs dry so a packet resumes where it stopped.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + BEAT_W'(1);
        end
    end

`ifdef FIFO_RD_STATS_EN
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rd_count <= '0;
        end else if (pop && (rd_count != 16'hFFFF)) begin
            rd_count <= rd_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

    localparam int DATA_WIDTH = 8;
    localparam int PKT_LEN    = 8;

    logic                  rclk;
    logic                  rrst;
    logic                  fifo_ren;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;
`ifdef FIFO_RD_STATS_EN
    logic [15:0]           rd_count;
`endif

    fifo_rd_stream #(
        .DATA_WIDTH (DATA_WIDTH),
        .PKT_LEN    (PKT_LEN)
    ) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .fifo_ren   (fifo_ren),
        .fifo_rdata (fifo_rdata),
        .fifo_empty (fifo_empty),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last)
`ifdef FIFO_RD_STATS_EN
       ,.rd_count   (rd_count)
`endif
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Emulated async_fifo contents and the bench-side flow state.
    int  q[$];
    bit  hold_empty = 1'b0;
    bit  rd_s = 1'b0;

    // Reference model: words taken out of the FIFO but not yet accepted.
    int  exp_q[$];
    int  held = 0;
    bit  last_read = 1'b0;
    int  beat = 0;
    int  pops = 0;
    int  rdc = 0;
    int  cyc = 0;
    bit  stall_prev = 1'b0;
    int  prev_data = 0;
    bit  prev_last = 1'b0;

    // Per-test logs of accepted words.
    int  pop_data[$];
    int  pop_last[$];
    int  pop_cyc[$];
    int  first_ren = -1;
    int  first_valid = -1;

    always @(negedge rclk) begin
        bit exp_valid;
        bit exp_pop;
        bit exp_ren;
        cyc++;
        if (rrst) begin
            chk("rst_ren", fifo_ren, 0);
            chk("rst_valid", m_valid, 0);
            chk("rst_last", m_last, 0);
            chk("rst_data", m_data, 0);
`ifdef FIFO_RD_STATS_EN
            chk("rst_rd_count", rd_count, 0);
`endif
            exp_q.delete();
            held = 0;
            last_read = 0;
            beat = 0;
            pops = 0;
            rdc = 0;
            stall_prev = 0;
            rd_s = 0;
        end else begin
            exp_valid = (held - int'(last_read)) > 0;
            exp_pop   = exp_valid && m_ready;
            exp_ren   = !fifo_empty && ((held - int'(exp_pop)) < 2);
            chk("m_valid", m_valid, exp_valid);
            chk("fifo_ren", fifo_ren, exp_ren);
            chk("occ_le2", dut.occ <= 2, 1);
            if (stall_prev) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, prev_data);
                chk("stall_last", m_last, prev_last);
            end
            if (exp_valid)
                chk("m_last", m_last, beat == PKT_LEN - 1);
`ifdef FIFO_RD_STATS_EN
            chk("rd_count", rd_count, rdc);
`endif
            if (exp_pop) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 1, 0);
                end else begin
                    chk("m_data", m_data, exp_q.pop_front());
                end
                pop_data.push_back(int'(m_data));
                pop_last.push_back(int'(m_last));
                pop_cyc.push_back(cyc);
                beat = (beat + 1) % PKT_LEN;
                pops++;
                if (rdc < 65535) rdc++;
            end
            rd_s = fifo_ren && !fifo_empty;
            if (rd_s) begin
                exp_q.push_back(q[0]);
                if (first_ren < 0) first_ren = cyc;
            end
            if (m_valid && first_valid < 0) first_valid = cyc;
            held = held + int'(rd_s) - int'(exp_pop);
            last_read = rd_s;
            stall_prev = m_valid && !m_ready;
            prev_data = int'(m_data);
            prev_last = m_last;
        end
    end

    task automatic update_empty();
        fifo_empty = hold_empty || (q.size() == 0);
    endtask

    task automatic step();
        @(posedge rclk);
        #1;
        if (rd_s) fifo_rdata = DATA_WIDTH'(q.pop_front());
        else      fifo_rdata = DATA_WIDTH'($urandom);
        update_empty();
    endtask

    task automatic load(input int first, input int last);
        for (int i = first; i <= last; i++) q.push_back(i & 'hFF);
        update_empty();
    endtask

    task automatic clear_logs();
        pop_data.delete();
        pop_last.delete();
        pop_cyc.delete();
        first_ren = -1;
        first_valid = -1;
    endtask

    task automatic run_pops(input string nm, input int n, input int budget);
        int k;
        k = 0;
        while (pop_data.size() < n && k < budget) begin
            step();
            k++;
        end
        if (pop_data.size() < n) chk({nm, "_timeout"}, pop_data.size(), n);
    endtask

    initial begin
        int nxt;
        rrst       = 1'b1;
        m_ready    = 1'b0;
        fifo_rdata = '0;
        load(1, 16);

        // T1: reset with a non-empty FIFO must issue no reads.
        repeat (3) step();
        clear_logs();
        m_ready = 1'b1;
        step();
        rrst = 1'b0;

        // T2: full-rate stream of 1..16.
        run_pops("t2", 16, 40);
        if (pop_data.size() >= 16) begin
            for (int i = 0; i < 16; i++) begin
                chk("t2_data", pop_data[i], i + 1);
                chk("t2_last", pop_last[i], (i == 7 || i == 15));
            end
            chk("t2_consecutive", pop_cyc[15] - pop_cyc[0], 15);
        end
        chk("t2_latency", first_valid - first_ren, 2);

        // T3: five stalled cycles mid-stream.
        clear_logs();
        load(17, 32);
        repeat (3) step();
        m_ready = 1'b0;
        repeat (5) step();
        chk("t3_ren_stopped", fifo_ren, 0);
        chk("t3_occ_full", dut.occ, 2);
        chk("t3_no_inflight", dut.inflight, 0);
        m_ready = 1'b1;
        run_pops("t3", 16, 40);
        if (pop_data.size() >= 16)
            for (int i = 0; i < 16; i++) chk("t3_order", pop_data[i], 17 + i);

        // T4: FIFO runs dry after three words of a packet.
        clear_logs();
        load(33, 35);
        run_pops("t4a", 3, 20);
        repeat (6) begin
            step();
            chk("t4_gap_valid", m_valid, 0);
        end
        load(36, 40);
        run_pops("t4b", 8, 30);
        if (pop_data.size() >= 8)
            for (int i = 0; i < 8; i++) begin
                chk("t4_data", pop_data[i], 33 + i);
                chk("t4_last", pop_last[i], i == 7);
            end

        // T5: reset pulse after five words of a packet.
        clear_logs();
        load(41, 60);
        run_pops("t5a", 5, 30);
        rrst = 1'b1;
        clear_logs();
        step();
        step();
        rrst = 1'b0;
        run_pops("t5b", 9, 40);
        if (pop_data.size() >= 9)
            for (int i = 0; i < 9; i++) chk("t5_last", pop_last[i], i == 7);

        // Randomized traffic with backpressure, FIFO gaps and occasional resets.
        nxt = 61;
        for (int c = 0; c < 4000; c++) begin
            step();
            if (rrst) rrst = 1'b0;
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) hold_empty = !hold_empty;
            if (q.size() < 10 && $urandom_range(0, 1) == 1) begin
                load(nxt, nxt);
                nxt++;
            end
            if ($urandom_range(0, 499) == 0) rrst = 1'b1;
            update_empty();
            clear_logs();
        end
        rrst = 1'b0;
        hold_empty = 1'b0;
        m_ready = 1'b1;
        update_empty();
        for (int k = 0; k < 100 && (q.size() != 0 || held != 0); k++) step();
        chk("drain_done", q.size() + held, 0);

`ifdef FIFO_RD_STATS_EN
        // T6: rd_count saturates.
        rrst = 1'b1;
        step();
        step();
        rrst = 1'b0;
        load(0, 69999);
        for (int k = 0; k < 75000 && pops < 70000; k++) begin
            step();
            if (pop_data.size() > 64) clear_logs();
        end
        chk("t6_pops", pops >= 70000, 1);
        chk("t6_rd_count_sat", rd_count, 16'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
